// File: rtl/vdp_xfer_master.sv
// vdp_xfer_master: host-side initiator for the VDP VRAM port.
// Performs a status-read resync, address LSB/MSB setup writes, then either
// a stream of data writes or backpressured, paced data reads.
module vdp_xfer_master #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LEN_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [7:0]        wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [7:0]        rdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic              busy,
  output logic              vdp_mode,
  output logic              vdp_rd_tick,
  output logic              vdp_wr_tick,
  output logic [7:0]        vdp_dout,
  input  logic [7:0]        vdp_din
);

  localparam int unsigned VADDR_W = 14;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ALO,
    AHI,
    WDATA,
    SETTLE,
    RDATA,
    RWAIT
  } state_t;

  state_t               state;
  logic                 write_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LEN_W-1:0]     remaining;

  logic [VADDR_W-1:0]   vaddr_c;
  logic                 wr_accept_c;
  logic                 last_c;
  logic                 empty_c;

  // VRAM-sized view of the latched address and data-phase helpers
  always_comb begin
    vaddr_c     = VADDR_W'(addr_q);
    wr_accept_c = wdata_valid && wdata_ready;
    last_c      = (remaining == LEN_W'(1));
    empty_c     = (remaining == LEN_W'(0));
  end

  // Transfer sequencer; every output is a register updated here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      remaining   <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      wdata_ready <= 1'b0;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      vdp_mode    <= 1'b0;
      vdp_rd_tick <= 1'b0;
      vdp_wr_tick <= 1'b0;
      vdp_dout    <= 8'h00;
    end else begin
      // strobes are single-cycle; mode only matters alongside a strobe
      vdp_rd_tick <= 1'b0;
      vdp_wr_tick <= 1'b0;
      vdp_mode    <= 1'b0;

      // a write byte accepted now is presented as a data write next cycle
      if (wr_accept_c) begin
        vdp_wr_tick <= 1'b1;
        vdp_dout    <= wdata;
        remaining   <= remaining - LEN_W'(1);
        if (last_c) begin
          wdata_ready <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            write_q     <= cmd_write;
            addr_q      <= cmd_addr;
            remaining   <= cmd_len;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            vdp_rd_tick <= 1'b1;
            vdp_mode    <= 1'b1;
            state       <= SYNC;
          end
        end
        SYNC: begin
          vdp_wr_tick <= 1'b1;
          vdp_mode    <= 1'b1;
          vdp_dout    <= vaddr_c[7:0];
          state       <= ALO;
        end
        ALO: begin
          vdp_wr_tick <= 1'b1;
          vdp_mode    <= 1'b1;
          vdp_dout    <= {1'b0, write_q, vaddr_c[13:8]};
          wdata_ready <= write_q && !empty_c;
          state       <= AHI;
        end
        AHI: begin
          if (empty_c) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (write_q) begin
            state <= WDATA;
          end else begin
            state <= SETTLE;
          end
        end
        WDATA: begin
          // count hits zero only after the final byte was taken
          if (empty_c) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        SETTLE: begin
          vdp_rd_tick <= 1'b1;
          state       <= RDATA;
        end
        RDATA: begin
          rdata       <= vdp_din;
          rdata_valid <= 1'b1;
          remaining   <= remaining - LEN_W'(1);
          state       <= RWAIT;
        end
        RWAIT: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            if (empty_c) begin
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              vdp_rd_tick <= 1'b1;
              state       <= RDATA;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_xfer_master.sv
// Directed testbench for vdp_xfer_master with a behavioural VRAM port model.
module tb_vdp_xfer_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [13:0] cmd_addr;
  logic [13:0] cmd_len;
  logic [7:0]  wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic        busy;
  logic        vdp_mode;
  logic        vdp_rd_tick;
  logic        vdp_wr_tick;
  logic [7:0]  vdp_dout;
  logic [7:0]  vdp_din;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  vdp_xfer_master #(.ADDR_W(14), .LEN_W(14)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .busy        (busy),
    .vdp_mode    (vdp_mode),
    .vdp_rd_tick (vdp_rd_tick),
    .vdp_wr_tick (vdp_wr_tick),
    .vdp_dout    (vdp_dout),
    .vdp_din     (vdp_din)
  );

  // VRAM port model: two-phase address latch, auto-increment, registered dout
  logic [7:0]  mem [0:16383];
  logic [13:0] v_addr = 14'h0;
  logic [7:0]  v_lo = 8'h0;
  logic        v_phase = 1'b0;
  logic [7:0]  v_dout = 8'h0;
  int          wr_data_cnt = 0;
  logic        pre_en = 1'b0;
  logic [13:0] pre_addr = 14'h0;
  logic [7:0]  pre_data = 8'h0;

  assign vdp_din = v_dout;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    v_dout <= mem[v_addr];
    if (vdp_rd_tick) begin
      if (vdp_mode) v_phase <= 1'b0;
      else          v_addr  <= v_addr + 14'd1;
    end
    if (vdp_wr_tick) begin
      if (vdp_mode) begin
        if (!v_phase) begin
          v_lo    <= vdp_dout;
          v_phase <= 1'b1;
        end else begin
          v_phase <= 1'b0;
          v_addr  <= {vdp_dout[5:0], v_lo};
        end
      end else begin
        mem[v_addr] <= vdp_dout;
        v_addr      <= v_addr + 14'd1;
        wr_data_cnt <= wr_data_cnt + 1;
      end
    end
  end

  // Both strobes high together is never legal
  int dual_cnt = 0;
  always @(negedge clk) begin
    if (vdp_rd_tick && vdp_wr_tick) dual_cnt <= dual_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vdp(input string tag, input logic rd, input logic wr, input logic md);
    chk({tag, "_rd"}, 32'(vdp_rd_tick), 32'(rd));
    chk({tag, "_wr"}, 32'(vdp_wr_tick), 32'(wr));
    if (rd || wr) chk({tag, "_mode"}, 32'(vdp_mode), 32'(md));
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  // Leaves the bench in cycle 1 of the new command
  task automatic issue(input logic w, input logic [13:0] a, input logic [13:0] l);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int base;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 14'h0;
    cmd_len     = 14'h0;
    wdata       = 8'h00;
    wdata_valid = 1'b0;
    rdata_ready = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();

    // reset values
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_dout", 32'(vdp_dout), 32'h00);
    chk("rst_mode", 32'(vdp_mode), 32'd0);
    chk_vdp("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // write 0x1234 len 3
    wdata       = 8'hA1;
    wdata_valid = 1'b1;
    issue(1'b1, 14'h1234, 14'd3);
    chk_vdp("w3_c1", 1'b1, 1'b0, 1'b1);
    chk("w3_c1_busy", 32'(busy), 32'd1);
    chk("w3_c1_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk_vdp("w3_c2", 1'b0, 1'b1, 1'b1);
    chk("w3_c2_dout", 32'(vdp_dout), 32'h34);
    tick();
    chk_vdp("w3_c3", 1'b0, 1'b1, 1'b1);
    chk("w3_c3_dout", 32'(vdp_dout), 32'h52);
    chk("w3_c3_wready", 32'(wdata_ready), 32'd1);
    tick();
    wdata = 8'hB2;
    chk_vdp("w3_c4", 1'b0, 1'b1, 1'b0);
    chk("w3_c4_dout", 32'(vdp_dout), 32'hA1);
    tick();
    wdata = 8'hC3;
    chk_vdp("w3_c5", 1'b0, 1'b1, 1'b0);
    chk("w3_c5_dout", 32'(vdp_dout), 32'hB2);
    tick();
    chk_vdp("w3_c6", 1'b0, 1'b1, 1'b0);
    chk("w3_c6_dout", 32'(vdp_dout), 32'hC3);
    chk("w3_c6_wready", 32'(wdata_ready), 32'd0);
    chk("w3_c6_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    wdata_valid = 1'b0;
    chk_vdp("w3_c7", 1'b0, 1'b0, 1'b0);
    chk("w3_c7_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("w3_c7_busy", 32'(busy), 32'd0);
    chk("w3_mem0", 32'(mem[14'h1234]), 32'hA1);
    chk("w3_mem1", 32'(mem[14'h1235]), 32'hB2);
    chk("w3_mem2", 32'(mem[14'h1236]), 32'hC3);

    // read 0x0010 len 4 with rdata_ready tied high
    preload(14'h0010, 8'h10);
    preload(14'h0011, 8'h11);
    preload(14'h0012, 8'h12);
    preload(14'h0013, 8'h13);
    rdata_ready = 1'b1;
    issue(1'b0, 14'h0010, 14'd4);
    chk_vdp("r4_c1", 1'b1, 1'b0, 1'b1);
    tick();
    chk("r4_c2_dout", 32'(vdp_dout), 32'h10);
    tick();
    chk_vdp("r4_c3", 1'b0, 1'b1, 1'b1);
    chk("r4_c3_dout", 32'(vdp_dout), 32'h00);
    tick();
    chk_vdp("r4_c4_settle", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_vdp($sformatf("r4_rd%0d", i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("r4_rd%0d_valid", i), 32'(rdata_valid), 32'd0);
      tick();
      chk_vdp($sformatf("r4_gap%0d", i), 1'b0, 1'b0, 1'b0);
      chk($sformatf("r4_gap%0d_valid", i), 32'(rdata_valid), 32'd1);
      chk($sformatf("r4_gap%0d_data", i), 32'(rdata), 32'h10 + 32'(i));
    end
    tick();
    chk("r4_end_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("r4_end_valid", 32'(rdata_valid), 32'd0);

    // read with a 5-cycle consumer stall after the first byte
    rdata_ready = 1'b0;
    issue(1'b0, 14'h0010, 14'd2);
    tick();
    tick();
    tick();
    tick();
    chk_vdp("st_c5", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_vdp($sformatf("st_hold%0d", i), 1'b0, 1'b0, 1'b0);
      chk($sformatf("st_hold%0d_valid", i), 32'(rdata_valid), 32'd1);
      chk($sformatf("st_hold%0d_data", i), 32'(rdata), 32'h10);
    end
    rdata_ready = 1'b1;
    tick();
    chk_vdp("st_c11", 1'b1, 1'b0, 1'b0);
    chk("st_c11_valid", 32'(rdata_valid), 32'd0);
    tick();
    chk("st_c12_valid", 32'(rdata_valid), 32'd1);
    chk("st_c12_data", 32'(rdata), 32'h11);
    tick();
    chk("st_c13_cmd_ready", 32'(cmd_ready), 32'd1);

    // write with a one-cycle gap in wdata_valid
    preload(14'h0102, 8'hEE);
    base        = wr_data_cnt;
    wdata       = 8'h11;
    wdata_valid = 1'b1;
    issue(1'b1, 14'h0100, 14'd2);
    tick();
    tick();
    tick();
    wdata_valid = 1'b0;
    chk_vdp("gp_c4", 1'b0, 1'b1, 1'b0);
    chk("gp_c4_dout", 32'(vdp_dout), 32'h11);
    tick();
    wdata       = 8'h22;
    wdata_valid = 1'b1;
    chk_vdp("gp_c5", 1'b0, 1'b0, 1'b0);
    chk("gp_c5_wready", 32'(wdata_ready), 32'd1);
    tick();
    wdata_valid = 1'b0;
    chk_vdp("gp_c6", 1'b0, 1'b1, 1'b0);
    chk("gp_c6_dout", 32'(vdp_dout), 32'h22);
    chk("gp_c6_wready", 32'(wdata_ready), 32'd0);
    tick();
    chk_vdp("gp_c7", 1'b0, 1'b0, 1'b0);
    chk("gp_c7_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("gp_count", 32'(wr_data_cnt - base), 32'd2);
    chk("gp_mem0", 32'(mem[14'h0100]), 32'h11);
    chk("gp_mem1", 32'(mem[14'h0101]), 32'h22);
    chk("gp_mem2", 32'(mem[14'h0102]), 32'hEE);

    // len 0 write to 0x3FFF, with cmd_valid held while busy
    base = wr_data_cnt;
    issue(1'b1, 14'h3FFF, 14'd0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 14'h0055;
    cmd_len   = 14'd1;
    chk_vdp("z_c1", 1'b1, 1'b0, 1'b1);
    tick();
    chk_vdp("z_c2", 1'b0, 1'b1, 1'b1);
    chk("z_c2_dout", 32'(vdp_dout), 32'hFF);
    tick();
    chk_vdp("z_c3", 1'b0, 1'b1, 1'b1);
    chk("z_c3_dout", 32'(vdp_dout), 32'h7F);
    chk("z_c3_wready", 32'(wdata_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk_vdp("z_c4", 1'b0, 1'b0, 1'b0);
    chk("z_c4_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk_vdp("z_c5", 1'b0, 1'b0, 1'b0);
    chk("z_c5_busy", 32'(busy), 32'd0);
    chk("z_count", 32'(wr_data_cnt - base), 32'd0);

    // reset asserted during the write data phase
    wdata       = 8'h5A;
    wdata_valid = 1'b1;
    issue(1'b1, 14'h0200, 14'd5);
    tick();
    tick();
    tick();
    tick();
    chk_vdp("mr_c5", 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk_vdp("mr_async", 1'b0, 1'b0, 1'b0);
    chk("mr_mode", 32'(vdp_mode), 32'd0);
    chk("mr_dout", 32'(vdp_dout), 32'h00);
    chk("mr_wready", 32'(wdata_ready), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset       = 1'b1;
    wdata_valid = 1'b0;
    tick();
    chk("mr_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk_vdp("mr_rel", 1'b0, 1'b0, 1'b0);
    rdata_ready = 1'b1;
    issue(1'b0, 14'h0010, 14'd1);
    chk_vdp("mr_sync", 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    tick();
    chk_vdp("mr_rd", 1'b1, 1'b0, 1'b0);
    tick();
    chk("mr_rd_valid", 32'(rdata_valid), 32'd1);
    chk("mr_rd_data", 32'(rdata), 32'h10);
    tick();
    chk("mr_end_cmd_ready", 32'(cmd_ready), 32'd1);

    chk("no_dual_strobe", 32'(dual_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
